// File: rtl/ppwm_pkg.sv
// Shared ppwm definitions: default counter width
// and the capture state encoding.
package ppwm_pkg;

  localparam int DEFAULT_COUNTER_WIDTH = 10;

  typedef enum logic {
    CAP_IDLE,
    CAP_MEASURE
  } capture_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async in), q (synchronized out).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time per PWM cycle.
// Ports: clk, rst_n, pwm_i, duty_o, period_o, valid_o, static_o.
module pwm_capture
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pwm_i,
  output logic [COUNTER_WIDTH-1:0] duty_o,
  output logic [COUNTER_WIDTH:0]   period_o,
  output logic                     valid_o,
  output logic                     static_o
);

  localparam int W = COUNTER_WIDTH;
  localparam logic [W:0] ONE = (W+1)'(1);

  logic s2;
  logic s3;
  logic rise;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pwm_i),
    .q     (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s3 <= 1'b0;
    else        s3 <= s2;
  end

  assign rise = s2 & ~s3;

  capture_state_e state;
  capture_state_e state_nxt;

  logic [W:0]   per_cnt;
  logic [W:0]   hi_cnt;
  logic [W:0]   per_nxt;
  logic [W:0]   hi_nxt;
  logic         tmo;
  logic         rep;
  logic         rep_static;
  logic [W-1:0] hi_sat;

  // A rise on the timeout value wins over the timeout.
  assign tmo = ~rise & (per_cnt == '1);

  assign hi_sat = hi_cnt[W] ? '1 : hi_cnt[W-1:0];

  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt + ONE;
    hi_nxt     = hi_cnt + {{W{1'b0}}, s2};
    rep        = 1'b0;
    rep_static = 1'b0;
    unique case (1'b1)
      rise: begin
        per_nxt   = ONE;
        hi_nxt    = ONE;
        state_nxt = CAP_MEASURE;
        rep       = (state == CAP_MEASURE);
      end
      tmo: begin
        per_nxt    = '0;
        hi_nxt     = '0;
        state_nxt  = CAP_IDLE;
        rep_static = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CAP_IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_o   <= '0;
      period_o <= '0;
      valid_o  <= 1'b0;
      static_o <= 1'b0;
    end else begin
      valid_o <= rep | rep_static;
      if (rep) begin
        duty_o   <= hi_sat;
        period_o <= per_cnt;
        static_o <= 1'b0;
      end else if (rep_static) begin
        duty_o   <= s2 ? '1 : '0;
        period_o <= '0;
        static_o <= 1'b1;
      end
    end
  end

endmodule
